// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type codes and parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  // Parity-type codes; 2'b11 is treated like PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_EVEN) || (ptype == PAR_ODD);
  endfunction

  function automatic logic parity_bit(input logic [1:0] ptype, input logic [7:0] data);
    return (ptype == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// TX FIFO read port: the transmitter pops with o_fifo_rd_en, data follows one cycle later.
interface uart_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] fifo_data;
  logic              empty;
  logic              o_fifo_rd_en;

  // Transmitter side
  modport master (
    input  fifo_data,
    input  empty,
    output o_fifo_rd_en
  );

  // FIFO side
  modport slave (
    output fifo_data,
    output empty,
    input  o_fifo_rd_en
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..divisor-1 and ticks on the last count; divisor 0/1 ticks every cycle.
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  // Next count and bit-period tick
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (divisor <= 16'd1) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else if (cnt_q == divisor - 16'd1) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a TX FIFO and sends start, 8 data bits LSB first,
// optional parity and stop bit(s). Define UART_TX_TWO_STOP_EN to add the i_two_stop input.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8  // only 8 is supported
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baud_divisor,
  input  logic [1:0]  i_parity_type,
  uart_tx_if.master   fifo,
  output logic        tx,
  output logic        o_busy,
  output logic        o_tx_done
`ifdef UART_TX_TWO_STOP_EN
  ,
  input  logic        i_two_stop
`endif
);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [15:0]       div_q, div_d;
  logic [1:0]        par_type_q, par_type_d;
  logic              par_bit_q, par_bit_d;
  logic              tx_q, tx_d;
  logic              rd_en, done, baud_clear, tick, stop_last;

  uart_baud_gen u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .divisor (div_q),
    .tick    (tick)
  );

`ifdef UART_TX_TWO_STOP_EN
  logic two_stop_q, two_stop_d;
  logic stop_cnt_q, stop_cnt_d;

  // Stop-period tracking: one flag marks that the first of two stop periods has elapsed
  always_comb begin
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    stop_last  = ~two_stop_q | stop_cnt_q;
    if (state_q == ST_LOAD) begin
      two_stop_d = i_two_stop;
      stop_cnt_d = 1'b0;
    end else if (state_q == ST_STOP && tick) begin
      stop_cnt_d = ~stop_last;
    end
  end

  // Stop-option registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end
`else
  assign stop_last = 1'b1;
`endif

  // FSM next state; tx_d is the value the line takes on entering the next bit
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    par_type_d = par_type_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    rd_en      = 1'b0;
    done       = 1'b0;
    baud_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo.empty) begin
          rd_en   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Parity bit is resolved here so later changes to i_parity_type cannot reach this frame
        shift_d    = fifo.fifo_data;
        div_d      = baud_divisor;
        par_type_d = i_parity_type;
        par_bit_d  = parity_bit(i_parity_type, fifo.fifo_data);
        bit_cnt_d  = '0;
        baud_clear = 1'b1;
        tx_d       = 1'b0;
        state_d    = ST_START;
      end
      ST_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == 3'd7) begin
            if (parity_enabled(par_type_q)) begin
              tx_d    = par_bit_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && stop_last) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
      par_type_q <= PAR_NONE;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      par_type_q <= par_type_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
    end
  end

  // Strobes are gated by reset so a held reset never pops the FIFO
  assign fifo.o_fifo_rd_en = rd_en & rst_n;
  assign o_tx_done         = done & rst_n;
  assign o_busy            = (state_q != ST_IDLE);
  assign tx                = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame table plus back-to-back, reset and mid-frame sequences.
module tb_uart_tx;
  import uart_pkg::*;

  typedef struct {
    logic [15:0] div;
    logic [1:0]  ptype;
    logic [7:0]  data;
    logic        two_stop;
    logic [15:0] mid_div;    // nonzero: divisor/parity changed during data bit 2
    logic [1:0]  mid_ptype;
    int          nbits;
    logic [15:0] bits;       // frame in transmission order, read left to right
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_divisor = 16'd4;
  logic [1:0]  i_parity_type = PAR_NONE;
  logic        tx, o_busy, o_tx_done;
`ifdef UART_TX_TWO_STOP_EN
  logic        two_stop = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          pop_cnt = 0;
  logic [7:0]  fifo_q[$];
  vec_t        vecs[$];
  logic [7:0]  b2b_bytes [3] = '{8'h11, 8'h22, 8'h33};

  uart_tx_if #(.DATA_W(8)) fif ();

  uart_tx #(.DATA_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .baud_divisor  (baud_divisor),
    .i_parity_type (i_parity_type),
    .fifo          (fif),
    .tx            (tx),
    .o_busy        (o_busy),
    .o_tx_done     (o_tx_done)
`ifdef UART_TX_TWO_STOP_EN
    ,
    .i_two_stop    (two_stop)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  // FIFO model: pop seen in a cycle delivers data just after the following edge
  initial begin
    logic pop;
    fif.empty     = 1'b1;
    fif.fifo_data = '0;
    forever begin
      @(negedge clk);
      pop = fif.o_fifo_rd_en;
      if (pop === 1'b1) begin
        n_cmp++;
        if (fif.empty !== 1'b0 || o_busy !== 1'b0 || rst_n !== 1'b1) begin
          n_err++;
          $display("FAIL pop_legal: rd_en with empty=%b busy=%b rst_n=%b, required 0/0/1",
                   fif.empty, o_busy, rst_n);
        end
      end
      @(posedge clk);
      #1;
      if (pop === 1'b1 && fifo_q.size() > 0) begin
        fif.fifo_data = fifo_q.pop_front();
        pop_cnt++;
      end
      fif.empty = (fifo_q.size() == 0);
    end
  end

  task automatic run_frame(input vec_t v, input int idx, input bit push);
    int unsigned eff;
    int          k, bad_tx, bad_busy, bad_done;
    bit          seen;
    logic        exp_bit;
    baud_divisor  = v.div;
    i_parity_type = v.ptype;
`ifdef UART_TX_TWO_STOP_EN
    two_stop = v.two_stop;
`endif
    if (push) fifo_q.push_back(v.data);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 50) begin
      @(negedge clk);
      k++;
      seen = (fif.o_fifo_rd_en === 1'b1);
    end
    check("pop_seen", idx, 32'(seen), 1);
    if (!seen) return;
    @(negedge clk);
    check("load_busy_tx", idx, {o_busy, tx}, 2'b11);
    eff = (v.div <= 16'd1) ? 1 : 32'(v.div);
    bad_busy = 0;
    bad_done = 0;
    for (int b = 0; b < v.nbits; b++) begin
      exp_bit = v.bits[v.nbits-1-b];
      bad_tx = 0;
      for (int unsigned c = 0; c < eff; c++) begin
        @(negedge clk);
        if (tx !== exp_bit) bad_tx++;
        if (o_busy !== 1'b1) bad_busy++;
        if (o_tx_done !== ((b == v.nbits-1) && (c == eff-1))) bad_done++;
        if (v.mid_div != 0 && b == 3 && c == 0) begin
          baud_divisor  = v.mid_div;
          i_parity_type = v.mid_ptype;
        end
      end
      check("tx_bit_bad_cycles", idx*100+b, bad_tx, 0);
    end
    check("busy_low_cycles", idx, bad_busy, 0);
    check("done_wrong_cycles", idx, bad_done, 0);
    @(negedge clk);
    check("idle_busy_tx", idx, {o_busy, tx}, 2'b01);
  endtask

  initial begin
    int   bad, k, n, pops_before;
    bit   got;
    logic lo_tx, st_tx;
    logic [7:0] rx;

    vecs.push_back('{16'd4, PAR_NONE, 8'hA5, 1'b0, 16'd0, PAR_NONE, 10, 16'b0101001011});
    vecs.push_back('{16'd2, PAR_EVEN, 8'h07, 1'b0, 16'd0, PAR_NONE, 11, 16'b01110000011});
    vecs.push_back('{16'd2, PAR_ODD,  8'h07, 1'b0, 16'd0, PAR_NONE, 11, 16'b01110000001});
    vecs.push_back('{16'd1, PAR_NONE, 8'h00, 1'b0, 16'd0, PAR_NONE, 10, 16'b0000000001});
    vecs.push_back('{16'd0, PAR_EVEN, 8'hFF, 1'b0, 16'd0, PAR_NONE, 11, 16'b01111111101});
    vecs.push_back('{16'd3, PAR_ODD,  8'h80, 1'b0, 16'd0, PAR_NONE, 11, 16'b00000000101});
    vecs.push_back('{16'd5, 2'b11,    8'h3C, 1'b0, 16'd0, PAR_NONE, 10, 16'b0001111001});
    vecs.push_back('{16'd7, PAR_EVEN, 8'h01, 1'b0, 16'd0, PAR_NONE, 11, 16'b01000000011});
    vecs.push_back('{16'd8, PAR_NONE, 8'h5A, 1'b0, 16'd2, PAR_EVEN, 10, 16'b0010110101});
    vecs.push_back('{16'd2, PAR_EVEN, 8'h5A, 1'b0, 16'd0, PAR_NONE, 11, 16'b00101101001});
`ifdef UART_TX_TWO_STOP_EN
    vecs.push_back('{16'd5, PAR_NONE, 8'hA5, 1'b1, 16'd0, PAR_NONE, 11, 16'b01010010111});
    vecs.push_back('{16'd5, PAR_ODD,  8'hA5, 1'b1, 16'd0, PAR_NONE, 12, 16'b010100101111});
`endif

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 0, 32'(tx), 1);
    check("rst_busy", 0, 32'(o_busy), 0);
    check("rst_rd_en", 0, 32'(fif.o_fifo_rd_en), 0);
    check("rst_done", 0, 32'(o_tx_done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle with empty FIFO
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (fif.o_fifo_rd_en !== 1'b0 || tx !== 1'b1 || o_busy !== 1'b0) bad++;
    end
    check("idle_empty_bad_cycles", 0, bad, 0);

    // Frame table
    foreach (vecs[i]) run_frame(vecs[i], i, 1'b1);

    // Three queued bytes, divisor 3: pops, 2-cycle gap, ordering
`ifdef UART_TX_TWO_STOP_EN
    two_stop = 1'b0;
`endif
    baud_divisor  = 16'd3;
    i_parity_type = PAR_NONE;
    pops_before = pop_cnt;
    foreach (b2b_bytes[i]) fifo_q.push_back(b2b_bytes[i]);
    got = 1'b0;
    k = 0;
    while (!got && k < 50) begin
      @(negedge clk);
      k++;
      got = (fif.o_fifo_rd_en === 1'b1);
    end
    check("b2b_first_pop", 0, 32'(got), 1);
    for (int f = 0; f < 3; f++) begin
      n = 0;
      got = 1'b0;
      rx = '0;
      lo_tx = 1'b0;
      st_tx = 1'b1;
      while (!got && n < 100) begin
        @(negedge clk);
        n++;
        if (n == 1) lo_tx = tx;
        if (n == 2) st_tx = tx;
        for (int b = 0; b < 8; b++) if (n == 6 + 3*b) rx[b] = tx;
        if (o_tx_done === 1'b1) got = 1'b1;
      end
      check("b2b_load_to_done", f, n, 31);
      check("b2b_load_tx", f, 32'(lo_tx), 1);
      check("b2b_start_tx", f, 32'(st_tx), 0);
      check("b2b_byte", f, rx, b2b_bytes[f]);
      @(negedge clk);
      check("b2b_idle_tx", f, 32'(tx), 1);
      check("b2b_idle_pop", f, 32'(fif.o_fifo_rd_en), (f < 2) ? 1 : 0);
    end
    repeat (10) @(negedge clk);
    check("b2b_pop_count", 0, pop_cnt - pops_before, 3);

    // Reset during DATA, next byte waiting in the FIFO
    baud_divisor  = 16'd4;
    i_parity_type = PAR_NONE;
    fifo_q.push_back(8'h00);
    got = 1'b0;
    k = 0;
    while (!got && k < 50) begin
      @(negedge clk);
      k++;
      got = (fif.o_fifo_rd_en === 1'b1);
    end
    check("rst_frame_pop", 0, 32'(got), 1);
    repeat (11) @(negedge clk);
    check("rst_pre_data_tx", 0, {o_busy, tx}, 2'b10);
    fifo_q.push_back(8'hC3);
    pops_before = pop_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx", 0, 32'(tx), 1);
    check("midrst_busy", 0, 32'(o_busy), 0);
    check("midrst_rd_en", 0, 32'(fif.o_fifo_rd_en), 0);
    check("midrst_done", 0, 32'(o_tx_done), 0);
    @(negedge clk);
    check("midrst_hold_rd_en", 0, 32'(fif.o_fifo_rd_en), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame('{16'd4, PAR_NONE, 8'hC3, 1'b0, 16'd0, PAR_NONE, 10, 16'b0110000111}, 50, 1'b0);
    check("midrst_pop_count", 0, pop_cnt - pops_before, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required the run to finish");
    $fatal(1, "time limit");
  end

endmodule
